// File: rtl/crossbar_pkg.sv
// Shared types and elaboration helpers for the crossbar request/response path.
package crossbar_pkg;

    localparam int TUSER_WIDTH_DEF = 4;

    typedef logic [TUSER_WIDTH_DEF-1:0] tag_t;

    // Bits needed to index n items, never less than one.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/crossbar_axis_slot.sv
// Single-entry valid/ready output register holding one request and its tag.
module crossbar_axis_slot
    import crossbar_pkg::*;
#(
    parameter int TDATA_WIDTH = 32,
    parameter int TUSER_WIDTH = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   load,
    input  logic [TDATA_WIDTH-1:0] load_tdata,
    input  logic [TUSER_WIDTH-1:0] load_tuser,
    output logic                   slot_free,
    output logic                   m_tvalid,
    input  logic                   m_tready,
    output logic [TDATA_WIDTH-1:0] m_tdata,
    output logic [TUSER_WIDTH-1:0] m_tuser
);

    logic                   vld_p1;
    logic [TDATA_WIDTH-1:0] data_p1;
    logic [TUSER_WIDTH-1:0] user_p1;

    // The slot can take a new entry when empty or when its entry leaves this cycle.
    assign slot_free = ~vld_p1 | m_tready;

    // Stage p1: registered request, valid under reset, payload not
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld_p1 <= 1'b0;
        end else if (load) begin
            vld_p1 <= 1'b1;
        end else if (m_tready) begin
            vld_p1 <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (load) begin
            data_p1 <= load_tdata;
            user_p1 <= load_tuser;
        end
    end

    assign m_tvalid = vld_p1;
    assign m_tdata  = data_p1;
    assign m_tuser  = user_p1;

endmodule

// File: rtl/crossbar_dispatch.sv
// Joins requests with in-order tags and issues them to S_QTY slaves,
// throttling each slave to MAX_OUTSTANDING requests in flight.
module crossbar_dispatch
    import crossbar_pkg::*;
#(
    parameter int S_QTY           = 4,
    parameter int TDATA_WIDTH     = 32,
    parameter int TUSER_WIDTH     = 4,
    parameter int DEST_WIDTH      = 2,
    parameter int MAX_OUTSTANDING = 8,
    parameter int CNT_WIDTH       = 4
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         s_axis_tag_tvalid,
    output logic                         s_axis_tag_tready,
    input  logic [TUSER_WIDTH-1:0]       s_axis_tag_tdata,
    input  logic                         s_axis_req_tvalid,
    output logic                         s_axis_req_tready,
    input  logic [TDATA_WIDTH-1:0]       s_axis_req_tdata,
    input  logic [DEST_WIDTH-1:0]        s_axis_req_tdest,
    output logic [S_QTY-1:0]             m_axis_req_tvalid,
    input  logic [S_QTY-1:0]             m_axis_req_tready,
    output logic [S_QTY*TDATA_WIDTH-1:0] m_axis_req_tdata,
    output logic [S_QTY*TUSER_WIDTH-1:0] m_axis_req_tuser,
    input  logic [S_QTY-1:0]             s_rsp_done,
    output logic [S_QTY*CNT_WIDTH-1:0]   outstanding,
    output logic                         err_bad_dest,
    output logic                         err_underflow
);

    if (DEST_WIDTH < clog2_min1(S_QTY)) begin : g_chk_dest_w
        $error("DEST_WIDTH too narrow for S_QTY");
    end
    if (CNT_WIDTH < clog2_min1(MAX_OUTSTANDING + 1)) begin : g_chk_cnt_w
        $error("CNT_WIDTH too narrow for MAX_OUTSTANDING");
    end
    if (MAX_OUTSTANDING < 1 || MAX_OUTSTANDING > (1 << TUSER_WIDTH) - 1) begin : g_chk_max
        $error("MAX_OUTSTANDING out of range for TUSER_WIDTH");
    end

    logic [S_QTY-1:0]     slot_free;
    logic [S_QTY-1:0]     can_take;
    logic [S_QTY-1:0]     fire_vec;
    logic [CNT_WIDTH-1:0] cnt_p1 [S_QTY];
    logic                 dest_ok;
    logic                 fire;
    logic                 underflow_hit;

    assign dest_ok = 32'(s_axis_req_tdest) < S_QTY;

    // Only the head's own target is considered, so a busy target blocks everything behind it.
    always_comb begin
        can_take = '0;
        for (int i = 0; i < S_QTY; i++) begin
            can_take[i] = (32'(s_axis_req_tdest) == 32'(i)) && slot_free[i]
                          && (cnt_p1[i] < CNT_WIDTH'(MAX_OUTSTANDING));
        end
    end

    assign fire              = s_axis_tag_tvalid & s_axis_req_tvalid & dest_ok & (|can_take);
    assign fire_vec          = fire ? can_take : '0;
    assign s_axis_tag_tready = fire;
    assign s_axis_req_tready = fire;

    for (genvar g = 0; g < S_QTY; g++) begin : g_slot
        crossbar_axis_slot #(
            .TDATA_WIDTH(TDATA_WIDTH),
            .TUSER_WIDTH(TUSER_WIDTH)
        ) u_slot (
            .clk       (clk),
            .reset     (reset),
            .load      (fire_vec[g]),
            .load_tdata(s_axis_req_tdata),
            .load_tuser(s_axis_tag_tdata),
            .slot_free (slot_free[g]),
            .m_tvalid  (m_axis_req_tvalid[g]),
            .m_tready  (m_axis_req_tready[g]),
            .m_tdata   (m_axis_req_tdata[g*TDATA_WIDTH +: TDATA_WIDTH]),
            .m_tuser   (m_axis_req_tuser[g*TUSER_WIDTH +: TUSER_WIDTH])
        );

        assign outstanding[g*CNT_WIDTH +: CNT_WIDTH] = cnt_p1[g];
    end

    // A response with nothing outstanding is flagged unless a fire to that slave cancels it.
    always_comb begin
        underflow_hit = 1'b0;
        for (int i = 0; i < S_QTY; i++) begin
            if (s_rsp_done[i] && !fire_vec[i] && (cnt_p1[i] == '0)) begin
                underflow_hit = 1'b1;
            end
        end
    end

    // Stage p1: in-flight counters and sticky error flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < S_QTY; i++) begin
                cnt_p1[i] <= '0;
            end
        end else begin
            for (int i = 0; i < S_QTY; i++) begin
                case ({fire_vec[i], s_rsp_done[i]})
                    2'b10:   cnt_p1[i] <= cnt_p1[i] + CNT_WIDTH'(1);
                    2'b01:   if (cnt_p1[i] != '0) cnt_p1[i] <= cnt_p1[i] - CNT_WIDTH'(1);
                    default: cnt_p1[i] <= cnt_p1[i];
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            err_bad_dest  <= 1'b0;
            err_underflow <= 1'b0;
        end else begin
            if (s_axis_req_tvalid && !dest_ok) err_bad_dest <= 1'b1;
            if (underflow_hit) err_underflow <= 1'b1;
        end
    end

endmodule

// File: tb/tb_crossbar_dispatch.sv
// Directed bench for crossbar_dispatch with a per-cycle reference model.
module tb_crossbar_dispatch;

    localparam int S = 4, DW = 32, TW = 4, XW = 2, MAXO = 8, CW = 4;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    logic          tag_v, req_v, tag_rdy, req_rdy, e_bd, e_uf;
    logic [TW-1:0] tag_d;
    logic [DW-1:0] req_d;
    logic [XW-1:0] req_dest;
    logic [S-1:0]  m_v, m_r, done;
    logic [S*DW-1:0] m_d;
    logic [S*TW-1:0] m_u;
    logic [S*CW-1:0] outs;

    logic          b_tag_v, b_req_v, b_tag_rdy, b_req_rdy, b_e_bd, b_e_uf;
    logic [TW-1:0] b_tag_d;
    logic [DW-1:0] b_req_d;
    logic [XW-1:0] b_req_dest;
    logic [2:0]    b_m_v, b_m_r, b_done;
    logic [3*DW-1:0] b_m_d;
    logic [3*TW-1:0] b_m_u;
    logic [3*CW-1:0] b_outs;

    int checks = 0;
    int failures = 0;

    crossbar_dispatch dut (
        .clk(clk), .reset(reset),
        .s_axis_tag_tvalid(tag_v), .s_axis_tag_tready(tag_rdy), .s_axis_tag_tdata(tag_d),
        .s_axis_req_tvalid(req_v), .s_axis_req_tready(req_rdy), .s_axis_req_tdata(req_d),
        .s_axis_req_tdest(req_dest),
        .m_axis_req_tvalid(m_v), .m_axis_req_tready(m_r), .m_axis_req_tdata(m_d),
        .m_axis_req_tuser(m_u), .s_rsp_done(done), .outstanding(outs),
        .err_bad_dest(e_bd), .err_underflow(e_uf)
    );

    crossbar_dispatch #(.S_QTY(3)) dut3 (
        .clk(clk), .reset(reset),
        .s_axis_tag_tvalid(b_tag_v), .s_axis_tag_tready(b_tag_rdy), .s_axis_tag_tdata(b_tag_d),
        .s_axis_req_tvalid(b_req_v), .s_axis_req_tready(b_req_rdy), .s_axis_req_tdata(b_req_d),
        .s_axis_req_tdest(b_req_dest),
        .m_axis_req_tvalid(b_m_v), .m_axis_req_tready(b_m_r), .m_axis_req_tdata(b_m_d),
        .m_axis_req_tuser(b_m_u), .s_rsp_done(b_done), .outstanding(b_outs),
        .err_bad_dest(b_e_bd), .err_underflow(b_e_uf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h t=%0t", name, act, exp, $time);
        end
    endtask

    // Reference model: state as it will be after the coming clock edge.
    int            md_cnt  [S];
    bit            md_vld  [S];
    logic [DW-1:0] md_data [S];
    logic [TW-1:0] md_user [S];
    bit            md_uf;

    always @(negedge clk) begin : compare
        bit efire;
        int d;
        int c;
        if (reset) begin
            for (int i = 0; i < S; i++) begin
                md_cnt[i] = 0;
                md_vld[i] = 1'b0;
            end
            md_uf = 1'b0;
        end else begin
            d = int'(req_dest);
            efire = tag_v && req_v && (d < S) && (!md_vld[d] || m_r[d]) && (md_cnt[d] < MAXO);
            chk("req_tready", req_rdy, efire);
            chk("tag_tready", tag_rdy, efire);
            for (int i = 0; i < S; i++) begin
                chk($sformatf("m_tvalid[%0d]", i), m_v[i], md_vld[i]);
                if (md_vld[i]) begin
                    chk($sformatf("m_tdata[%0d]", i), m_d[i*DW +: DW], md_data[i]);
                    chk($sformatf("m_tuser[%0d]", i), m_u[i*TW +: TW], md_user[i]);
                end
                chk($sformatf("outstanding[%0d]", i), outs[i*CW +: CW], md_cnt[i]);
            end
            chk("err_underflow", e_uf, md_uf);
            chk("err_bad_dest", e_bd, 1'b0);
            for (int i = 0; i < S; i++) begin
                if (md_vld[i] && m_r[i]) md_vld[i] = 1'b0;
                c = md_cnt[i] + ((efire && d == i) ? 1 : 0) - (done[i] ? 1 : 0);
                if (c < 0) begin
                    c = 0;
                    md_uf = 1'b1;
                end
                md_cnt[i] = c;
            end
            if (efire) begin
                md_vld[d]  = 1'b1;
                md_data[d] = req_d;
                md_user[d] = tag_d;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int dest, input logic [DW-1:0] data, input logic [TW-1:0] tag);
        bit ok;
        ok = 1'b0;
        tag_v = 1'b1; tag_d = tag; req_v = 1'b1; req_d = data; req_dest = XW'(dest);
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (req_rdy) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (ok) tick();
        tag_v = 1'b0; req_v = 1'b0;
        chk($sformatf("fire_within_budget d%0d tag%0d", dest, tag), ok, 1'b1);
    endtask

    task automatic do_reset();
        tick();
        reset = 1'b1;
        tag_v = 1'b0; req_v = 1'b0; done = '0; m_r = '1;
        #1;
        chk("reset m_tvalid", m_v, '0);
        chk("reset outstanding", outs, '0);
        chk("reset err_underflow", e_uf, 1'b0);
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired checks=%0d", checks);
        $fatal(1, "bench timeout");
    end

    initial begin
        tag_v = 0; req_v = 0; tag_d = '0; req_d = '0; req_dest = '0; m_r = '1; done = '0;
        b_tag_v = 0; b_req_v = 0; b_tag_d = '0; b_req_d = '0; b_req_dest = '0; b_m_r = '1; b_done = '0;
        tick();
        tick();
        chk("init m_tvalid", m_v, '0);
        chk("init outstanding", outs, '0);
        chk("init err_bad_dest", e_bd, 1'b0);
        chk("init err_underflow", e_uf, 1'b0);
        reset = 1'b0;

        // 1: one request to each slave
        for (int k = 0; k < 4; k++) begin
            send(k, 32'hA0 + k, TW'(k));
            if (k == 0) begin
                chk("t1 first tvalid", m_v, 4'b0001);
                chk("t1 first tdata", m_d[31:0], 32'hA0);
                chk("t1 first tuser", m_u[3:0], 4'h0);
            end
        end
        chk("t1 last tvalid", m_v, 4'b1000);
        chk("t1 slot3 tdata", m_d[127:96], 32'hA3);
        chk("t1 slot3 tuser", m_u[15:12], 4'h3);
        chk("t1 outstanding", outs, 16'h1111);
        tick();
        chk("t1 pulse ends", m_v, 4'b0000);

        // 2: in-flight limit on slave 2
        do_reset();
        for (int k = 0; k < 8; k++) send(2, 32'hB0 + k, TW'(k));
        chk("t2 count at limit", outs[11:8], 4'd8);
        tag_v = 1; tag_d = 4'd8; req_v = 1; req_d = 32'hB8; req_dest = 2'd2;
        repeat (3) begin
            @(negedge clk);
            chk("t2 ninth req_tready", req_rdy, 1'b0);
            chk("t2 ninth tag_tready", tag_rdy, 1'b0);
            tick();
        end
        done[2] = 1'b1;
        @(negedge clk);
        chk("t2 stall during done", req_rdy, 1'b0);
        tick();
        done[2] = 1'b0;
        chk("t2 count after done", outs[11:8], 4'd7);
        @(negedge clk);
        chk("t2 ninth fires", req_rdy, 1'b1);
        tick();
        tag_v = 0; req_v = 0;
        chk("t2 count back at limit", outs[11:8], 4'd8);
        chk("t2 ninth tuser", m_u[11:8], 4'd8);
        chk("t2 ninth tdata", m_d[95:64], 32'hB8);

        // 3: head-of-line blocking behind a full slave 1
        do_reset();
        m_r = 4'b1101;
        send(1, 32'hC0, 4'd0);
        tag_v = 1; tag_d = 4'd1; req_v = 1; req_d = 32'hC1; req_dest = 2'd1;
        repeat (3) begin
            @(negedge clk);
            chk("t3 head blocked", req_rdy, 1'b0);
            tick();
        end
        m_r[1] = 1'b1;
        @(negedge clk);
        chk("t3 head fires", req_rdy, 1'b1);
        tick();
        chk("t3 slot1 tuser", m_u[7:4], 4'd1);
        chk("t3 slot1 tdata", m_d[63:32], 32'hC1);
        tag_d = 4'd2; req_d = 32'hC2; req_dest = 2'd0;
        @(negedge clk);
        chk("t3 follower fires", req_rdy, 1'b1);
        tick();
        tag_v = 0; req_v = 0;
        chk("t3 tvalid", m_v, 4'b0001);
        chk("t3 slot0 tuser", m_u[3:0], 4'd2);
        chk("t3 slot0 tdata", m_d[31:0], 32'hC2);

        // 4: fire and response together on slave 3
        do_reset();
        for (int k = 0; k < 5; k++) send(3, 32'hD0 + k, TW'(k));
        chk("t4 count before", outs[15:12], 4'd5);
        done[3] = 1'b1;
        send(3, 32'hD5, 4'd5);
        done[3] = 1'b0;
        chk("t4 count unchanged", outs[15:12], 4'd5);
        chk("t4 tuser", m_u[15:12], 4'd5);

        // 5a: response with nothing outstanding
        do_reset();
        chk("t5 underflow clear", e_uf, 1'b0);
        done[0] = 1'b1;
        tick();
        done[0] = 1'b0;
        chk("t5 underflow set", e_uf, 1'b1);
        chk("t5 count floor", outs[3:0], 4'd0);
        tick();
        chk("t5 underflow sticky", e_uf, 1'b1);

        // 5b: bad destination on a three-slave instance
        chk("t5 bad_dest clear", b_e_bd, 1'b0);
        b_tag_v = 1; b_tag_d = 4'd0; b_req_v = 1; b_req_d = 32'hF0; b_req_dest = 2'd3;
        repeat (4) begin
            @(negedge clk);
            chk("t5 bad req_tready", b_req_rdy, 1'b0);
            chk("t5 bad tag_tready", b_tag_rdy, 1'b0);
            tick();
            chk("t5 bad_dest set", b_e_bd, 1'b1);
            chk("t5 bad no issue", b_m_v, 3'b000);
            chk("t5 bad no count", b_outs, 12'h000);
        end
        chk("t5 bad no underflow", b_e_uf, 1'b0);

        // 6: reset in the middle of traffic to slave 2
        do_reset();
        send(2, 32'hE0, 4'd0);
        send(2, 32'hE1, 4'd1);
        tick();
        m_r[2] = 1'b0;
        send(2, 32'hE2, 4'd2);
        chk("t6 tvalid before reset", m_v[2], 1'b1);
        chk("t6 count before reset", outs[11:8], 4'd3);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("t6 async tvalid", m_v, 4'b0000);
        chk("t6 async outstanding", outs, 16'h0000);
        tick();
        tick();
        reset = 1'b0;
        m_r = '1;
        send(2, 32'hE0, 4'd0);
        chk("t6 after reset tvalid", m_v, 4'b0100);
        chk("t6 after reset tuser", m_u[11:8], 4'd0);
        chk("t6 after reset tdata", m_d[95:64], 32'hE0);
        chk("t6 after reset count", outs[11:8], 4'd1);
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/crossbar_dispatch.md
Name: crossbar_dispatch

Overview:
Request-side counterpart of the crossbar reorder buffer. Joins each incoming request with the next in-order tag from the reorder buffer's tag channel, then routes the request to one of S_QTY slave ports with the tag carried in tuser. Slaves return responses out of order, tagged, straight to the reorder buffer.
Tracks per-slave outstanding requests and throttles issue, so no slave is handed more than MAX_OUTSTANDING requests in flight.

Parameters:
S_QTY, 4, number of slave ports
TDATA_WIDTH, 32, request payload width
TUSER_WIDTH, 4, tag width; must equal the reorder buffer's TUSER_WIDTH
DEST_WIDTH, 2, width of the destination select; must satisfy 2**DEST_WIDTH >= S_QTY
MAX_OUTSTANDING, 8, per-slave in-flight limit; range 1..2**TUSER_WIDTH-1
CNT_WIDTH, 4, outstanding counter width; must satisfy 2**CNT_WIDTH > MAX_OUTSTANDING

Ports:
clk  in  1  clock
reset  in  1  asynchronous active-high reset
s_axis_tag_tvalid  in  1  tag available from reorder buffer
s_axis_tag_tready  out  1  tag consumed
s_axis_tag_tdata  in  TUSER_WIDTH  tag value
s_axis_req_tvalid  in  1  request valid
s_axis_req_tready  out  1  request accepted
s_axis_req_tdata  in  TDATA_WIDTH  request payload
s_axis_req_tdest  in  DEST_WIDTH  target slave index
m_axis_req_tvalid  out  S_QTY  per-slave request valid
m_axis_req_tready  in  S_QTY  per-slave ready
m_axis_req_tdata  out  S_QTY x TDATA_WIDTH  per-slave payload
m_axis_req_tuser  out  S_QTY x TUSER_WIDTH  per-slave tag
s_rsp_done  in  S_QTY  one-cycle pulse per response returned by slave i
outstanding  out  S_QTY x CNT_WIDTH  per-slave in-flight count
err_bad_dest  out  1  sticky: head request had tdest >= S_QTY
err_underflow  out  1  sticky: s_rsp_done[i] arrived with outstanding[i] == 0

Behaviour:
- Reset (async assert; release is synchronous to clk):
  - all m_axis_req_tvalid = 0, outstanding = 0, err flags = 0.
  - tdata/tuser registers are not reset.
- Fire condition, evaluated each cycle:
  - fire = tag_tvalid & req_tvalid & dest_ok & slot_free[d] & (outstanding[d] < MAX_OUTSTANDING), where d = tdest.
  - dest_ok = (tdest < S_QTY).
  - slot_free[d] = ~m_axis_req_tvalid[d] | m_axis_req_tready[d].
  - s_axis_tag_tready = s_axis_req_tready = fire. Both streams are consumed in the same cycle or neither is.
  - tready is combinational on the input valids. This is permitted because neither upstream waits on tready.
- Ordering:
  - Strict in-order issue, at most one request per cycle.
  - Head-of-line blocking when the head's target is busy or at its limit; a later request to an idle slave must not bypass it.
- Output register per slave:
  - On fire: m tvalid[d] <= 1, tdata[d] <= req_tdata, tuser[d] <= tag_tdata.
  - Else on tready[d]: tvalid[d] <= 0.
  - Latency is 1 cycle from fire to m tvalid. Full throughput is one request per cycle to the same slave while tready is held high.
- Outstanding counter, per slave:
  - fire to i increments; s_rsp_done[i] decrements.
  - Both in the same cycle: unchanged.
  - s_rsp_done[i] with count 0: count stays 0 and err_underflow is set.
  - Count never exceeds MAX_OUTSTANDING.
  - The count includes the request still sitting in the output register.
- Bad destination:
  - A head request with tdest >= S_QTY is not consumed; its tag is not consumed either.
  - err_bad_dest is set while such a request is valid at the head.
  - The pipe stalls until reset. This is fatal by design; integrators guarantee valid tdest.
- Error flags clear only on reset.
- Reset mid-operation: all in-flight state is discarded. The reorder buffer is reset together with this block.

Decomposition:
- crossbar_pkg holds:
  - function clog2_min1 for DEST_WIDTH/CNT_WIDTH checks
  - typedef of the tag type (logic [TUSER_WIDTH-1:0]), parameterised via the package default
- Elaboration-time assertions on the parameter constraints live in the module.
- One sub-module: crossbar_axis_slot, a single-entry output register with valid/ready. Instantiated S_QTY times.

Test Plan:
1. Reset, tags 0..3 available, requests to dest 0,1,2,3 with data 0xA0..0xA3 and all tready=1 → each m_axis_req_tvalid[i] pulses one cycle after its fire, carrying tdata 0xA0+i and tuser i; outstanding = 1,1,1,1.
2. MAX_OUTSTANDING=8, eight requests to dest 2 with no s_rsp_done → 8 fires back-to-back. Ninth request stalls (req_tready=0, tag_tready=0). One s_rsp_done[2] pulse → ninth fires the next cycle; outstanding[2] stays 8.
3. Head request to dest 1 with m_axis_req_tready[1]=0 and slot full, followed by a request to dest 0 → nothing fires (head-of-line blocking). Raising tready[1] → dest1 fires, then dest0 fires on the following cycle.
4. Fire to dest 3 and s_rsp_done[3] in the same cycle with outstanding[3]=5 → outstanding[3] remains 5.
5. s_rsp_done[0] with outstanding[0]=0 → err_underflow=1 and outstanding[0]=0. Separately, tdest=3 with S_QTY=3 → err_bad_dest=1, no tag consumed, stall persists.
6. Assert reset mid-burst while tvalid[2]=1 and outstanding[2]=3 → immediately tvalid=0 and outstanding=0. After release, tag 0 with a request to dest 2 issues normally.
